// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and flag helper shared by alu_mc
package alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } flags_t;

    // res arrives zero-extended, so bits above w-1 never disturb Z
    function automatic flags_t calc_flags(input logic [63:0] res, input int unsigned w, input logic v);
        return '{z: res == '0, n: res[6'(w - 1)], v: v};
    endfunction
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: start/busy/done handshake plus operand and result bus of alu_mc
//   master drives start, ALUop, Ain, Bin; slave drives busy, done, out, Z, N, V
interface alu_mc_if #(parameter int WIDTH = 16);
    logic             start;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic             N;
    logic             V;
    modport master (output start, ALUop, Ain, Bin, input busy, done, out, Z, N, V);
    modport slave  (input start, ALUop, Ain, Bin, output busy, done, out, Z, N, V);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier datapath, one partial product per step
//   load latches A/B and clears acc; step adds/shifts; last flags the final step
module alu_mul_iter #(parameter int WIDTH = 16) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               step,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CNTW = $clog2(WIDTH + 1);

    // mcand holds A pre-shifted by the current iteration index
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d = load ? {{WIDTH{1'b0}}, A} : step ? mcand_q << 1 : mcand_q;
        mplr_d  = load ? B : step ? mplr_q >> 1 : mplr_q;
        acc_d   = load ? '0 : (step && mplr_q[0]) ? acc_q + mcand_q : acc_q;
        cnt_d   = load ? CNTW'(WIDTH) : step ? cnt_q - CNTW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = cnt_q == CNTW'(1);
endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU, single-cycle logic/arith ops plus iterative multiply
//   clk, reset_n (async, active low); bus: alu_mc_if slave (start/ALUop/Ain/Bin in,
//   busy/done/out/Z/N/V out)
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     reset_n,
    alu_mc_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    flags_t             flags_q, flags_d;
    logic [WIDTH-1:0]   out_q, out_d, sc_res, sum, diff;
    logic               done_q, done_d, load, step, last, sc_v;
    logic [2*WIDTH-1:0] acc;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .A       (bus.Ain),
        .B       (bus.Bin),
        .step    (step),
        .acc     (acc),
        .last    (last)
    );

    assign sum  = bus.Ain + bus.Bin;
    assign diff = bus.Ain - bus.Bin;

    always_comb begin
        sc_res = bus.ALUop == OP_ADD  ? sum :
                 bus.ALUop == OP_SUB  ? diff :
                 bus.ALUop == OP_AND  ? bus.Ain & bus.Bin :
                 bus.ALUop == OP_NOTB ? ~bus.Bin :
                 bus.ALUop == OP_OR   ? bus.Ain | bus.Bin :
                 bus.ALUop == OP_XOR  ? bus.Ain ^ bus.Bin : '0;
        sc_v   = bus.ALUop == OP_ADD ? (bus.Ain[MSB] == bus.Bin[MSB]) && (sum[MSB] != bus.Ain[MSB]) :
                 bus.ALUop == OP_SUB ? (bus.Ain[MSB] != bus.Bin[MSB]) && (diff[MSB] != bus.Ain[MSB]) : 1'b0;
    end

    // start is only looked at in IDLE, so requests during a multiply vanish
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                if (bus.ALUop == OP_MUL) begin
                    load    = 1'b1;
                    state_d = S_MUL;
                end else begin
                    out_d   = sc_res;
                    flags_d = calc_flags(64'(sc_res), WIDTH, sc_v);
                    done_d  = 1'b1;
                end
            end
            S_MUL: begin
                step    = 1'b1;
                state_d = last ? S_FIN : S_MUL;
            end
            S_FIN: begin
                out_d   = acc[MSB:0];
                flags_d = calc_flags(64'(acc[MSB:0]), WIDTH, |acc[2*WIDTH-1:WIDTH]);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            flags_q <= '{z: 1'b1, n: 1'b0, v: 1'b0};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = state_q != S_IDLE;
    assign bus.done = done_q;
    assign bus.out  = out_q;
    assign bus.Z    = flags_q.z;
    assign bus.N    = flags_q.n;
    assign bus.V    = flags_q.v;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table, directed and randomized checks of alu_mc at WIDTH=16 and WIDTH=8
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(16)) b16();
    alu_mc_if #(.WIDTH(8))  b8();

    alu_mc #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));
    alu_mc #(.WIDTH(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(b8));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] out;
        logic        z, n, v;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b, out;
        logic        z, n, v;
    } vec_t;

    // plain-integer reference: signed range test for overflow, full product for MUL
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int w);
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint half = longint'(1) << (w - 1);
        longint mask = (longint'(1) << w) - 1;
        longint sa   = ua >= half ? ua - 2 * half : ua;
        longint sb   = ub >= half ? ub - 2 * half : ub;
        longint r    = 0;
        logic   v    = 1'b0;
        exp_t   e;
        case (op)
            OP_ADD:  begin r = ua + ub; v = (sa + sb >= half) || (sa + sb < -half); end
            OP_SUB:  begin r = ua - ub; v = (sa - sb >= half) || (sa - sb < -half); end
            OP_AND:  r = ua & ub;
            OP_NOTB: r = ~ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            OP_MUL:  begin r = ua * ub; v = r > mask; end
            default: r = 0;
        endcase
        e.out = 16'(r & mask);
        e.z   = (r & mask) == 0;
        e.n   = ((r >> (w - 1)) & 1) != 0;
        e.v   = v;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // drives one request at the negedge and checks the registered result; leaves start high
    task automatic single16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input string nm);
        exp_t e = model(op, a, b, 16);
        @(negedge clk);
        b16.start = 1'b1; b16.ALUop = op; b16.Ain = a; b16.Bin = b;
        @(posedge clk); #1;
        chk({nm, "_done"}, b16.done, 1);
        chk({nm, "_out"}, b16.out, e.out);
        chk({nm, "_z"}, b16.Z, e.z);
        chk({nm, "_n"}, b16.N, e.n);
        chk({nm, "_v"}, b16.V, e.v);
    endtask

    task automatic single8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string nm);
        exp_t e = model(op, {8'h00, a}, {8'h00, b}, 8);
        @(negedge clk);
        b8.start = 1'b1; b8.ALUop = op; b8.Ain = a; b8.Bin = b;
        @(posedge clk); #1;
        b8.start = 1'b0;
        chk({nm, "_done"}, b8.done, 1);
        chk({nm, "_out"}, b8.out, e.out[7:0]);
        chk({nm, "_z"}, b8.Z, e.z);
        chk({nm, "_n"}, b8.N, e.n);
        chk({nm, "_v"}, b8.V, e.v);
    endtask

    // multiply with an optional ADD request injected at busy cycle 'inject'
    task automatic run_mul16(input logic [15:0] a, input logic [15:0] b, input int inject, input string nm);
        exp_t        e = model(OP_MUL, a, b, 16);
        logic [15:0] prev = b16.out;
        int          n = 0;
        bit          hold_ok = 1'b1, busy_ok = 1'b1;
        @(negedge clk);
        b16.start = 1'b1; b16.ALUop = OP_MUL; b16.Ain = a; b16.Bin = b;
        @(posedge clk); #1;
        chk({nm, "_busy_start"}, b16.busy, 1);
        while (n < 40) begin
            @(negedge clk);
            if (n == inject) begin
                b16.start = 1'b1; b16.ALUop = OP_ADD; b16.Ain = 16'h0001; b16.Bin = 16'h0001;
            end else b16.start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (b16.done) break;
            if (b16.out !== prev) hold_ok = 1'b0;
            if (b16.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, n, 17);
        chk({nm, "_hold"}, hold_ok, 1);
        chk({nm, "_busy_during"}, busy_ok, 1);
        chk({nm, "_busy_end"}, b16.busy, 0);
        chk({nm, "_out"}, b16.out, e.out);
        chk({nm, "_z"}, b16.Z, e.z);
        chk({nm, "_n"}, b16.N, e.n);
        chk({nm, "_v"}, b16.V, e.v);
        @(posedge clk); #1;
        chk({nm, "_done_once"}, b16.done, 0);
    endtask

    vec_t tbl[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b16.start = 1'b0; b16.ALUop = '0; b16.Ain = '0; b16.Bin = '0;
        b8.start  = 1'b0; b8.ALUop  = '0; b8.Ain  = '0; b8.Bin  = '0;
        tbl[0] = '{OP_ADD,  16'h1993, 16'h846C, 16'h9DFF, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{OP_NOTB, 16'h0000, 16'h1993, 16'hE66C, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{OP_SUB,  16'h0002, 16'h0004, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{OP_OR,   16'h8001, 16'h0100, 16'h8101, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{OP_XOR,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{OP_RSV,  16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0};

        #2 reset_n = 1'b0;
        #10;
        chk("rst_out", b16.out, 0);
        chk("rst_z", b16.Z, 1);
        chk("rst_n", b16.N, 0);
        chk("rst_v", b16.V, 0);
        chk("rst_busy", b16.busy, 0);
        chk("rst_done", b16.done, 0);
        chk("rst8_z", b8.Z, 1);
        @(negedge clk) reset_n = 1'b1;

        // start held high across the table: one result per cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            b16.start = 1'b1; b16.ALUop = tbl[i].op; b16.Ain = tbl[i].a; b16.Bin = tbl[i].b;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done", i), b16.done, 1);
            chk($sformatf("vec%0d_out", i), b16.out, tbl[i].out);
            chk($sformatf("vec%0d_z", i), b16.Z, tbl[i].z);
            chk($sformatf("vec%0d_n", i), b16.N, tbl[i].n);
            chk($sformatf("vec%0d_v", i), b16.V, tbl[i].v);
        end
        @(negedge clk) b16.start = 1'b0;
        @(posedge clk); #1;
        chk("tbl_done_drop", b16.done, 0);
        chk("tbl_out_hold", b16.out, 16'h0000);

        run_mul16(16'h0012, 16'h0034, -1, "mul_12x34");
        chk("mul_12x34_const", b16.out, 16'h03A8);
        run_mul16(16'h0100, 16'h0100, -1, "mul_ovf");
        chk("mul_ovf_const_v", b16.V, 1);

        run_mul16(16'h00FF, 16'h0003, 4, "mul_ign");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ign_no_done", b16.done, 0);
            chk("ign_out", b16.out, 16'h02FD);
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        b16.start = 1'b1; b16.ALUop = OP_MUL; b16.Ain = 16'h1234; b16.Bin = 16'h0056;
        @(posedge clk); #1;
        @(negedge clk) b16.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        chk("amid_out", b16.out, 0);
        chk("amid_z", b16.Z, 1);
        chk("amid_busy", b16.busy, 0);
        chk("amid_done", b16.done, 0);
        @(negedge clk) reset_n = 1'b1;
        single16(OP_ADD, 16'h0003, 16'h0004, "post_rst");
        chk("post_rst_const", b16.out, 16'h0007);
        chk("post_rst_busy", b16.busy, 0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [15:0] a  = 16'($urandom);
            logic [15:0] b  = i[0] ? 16'($urandom) : 16'($urandom_range(0, 255));
            if (op == OP_MUL) run_mul16(a, b, (i % 3 == 0) ? int'($urandom_range(0, 14)) : -1, $sformatf("rmul%0d", i));
            else single16(op, a, b, $sformatf("rnd%0d", i));
        end
        @(negedge clk) b16.start = 1'b0;

        begin
            int n = 0;
            @(negedge clk);
            b8.start = 1'b1; b8.ALUop = OP_MUL; b8.Ain = 8'h0F; b8.Bin = 8'h11;
            @(posedge clk); #1;
            @(negedge clk) b8.start = 1'b0;
            while (n < 30) begin
                if (n > 0) @(negedge clk);
                @(posedge clk); #1;
                n++;
                if (b8.done) break;
            end
            chk("w8_mul_latency", n, 9);
            chk("w8_mul_out", b8.out, 8'hFF);
            chk("w8_mul_v", b8.V, 0);
            chk("w8_mul_z", b8.Z, 0);
        end
        single8(OP_RSV, 8'hAB, 8'hCD, "w8_rsv");
        chk("w8_rsv_const", b8.out, 8'h00);
        single8(OP_ADD, 8'h7F, 8'h01, "w8_add_ovf");
        single8(OP_SUB, 8'h80, 8'h01, "w8_sub_ovf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, registered, multi-cycle ALU for the datapath.
- Single-cycle operations: ADD, SUB, AND, NOT-B, OR and XOR.
- Multi-cycle operation: iterative unsigned multiply.
- Status flags Z, N and V are registered alongside the result.
- A start/busy/done handshake lets the controller FSM issue an operation and wait for its completion.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
CNTW, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
ALUop  input  3  operation code, sampled with start
Ain  input  WIDTH  operand A, sampled with start
Bin  input  WIDTH  operand B, sampled with start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: out and flags just updated
out  output  WIDTH  registered result; holds until the next done
Z  output  1  out == 0
N  output  1  out[WIDTH-1]
V  output  1  overflow (see arithmetic rules)

Behaviour:
Reset (reset_n low, asynchronous, takes effect immediately, including mid-multiply):
- out=0, Z=1, N=0, V=0, busy=0, done=0.
- FSM goes to IDLE; counter and partial product are cleared.

Op encoding:
- 000 ADD, 001 SUB (A-B), 010 AND, 011 NOT B, 100 OR, 101 XOR, 110 MUL.
- 111 is reserved: treated as single-cycle, out=0, Z=1, N=0, V=0.

FSM states: IDLE, MUL, and FIN (single cycle).
- IDLE with start=1 and a non-MUL op at edge k:
  - out and flags are written at edge k; done=1 during cycle k+1.
  - FSM stays in IDLE.
  - Back-to-back starts are allowed: one result per cycle.
- IDLE with start=1 and MUL at edge k:
  - Latch A and B; clear the accumulator; counter=WIDTH.
  - busy=1 from edge k.
  - Go to MUL.
- MUL, each edge:
  - If multiplier LSB=1, acc += A shifted by the iteration index; shift the multiplier right; counter--.
  - The accumulator is 2*WIDTH bits wide.
  - When the counter reaches 0, go to FIN.
- FIN (edge k+WIDTH+1):
  - out = acc[WIDTH-1:0]; flags are written.
  - done pulses; busy drops at the same edge.
  - Go to IDLE.
  - MUL latency is therefore WIDTH+1 edges from the sampling edge.
- start while busy=1 is ignored entirely: no queueing, no effect on the multiply in progress.
- done never stays high for 2 consecutive cycles from the same operation.
- Outside a done event, out, Z, N and V hold their values.

Arithmetic rules (all results truncated to WIDTH bits):
- ADD: V = (A[msb]==B[msb]) && (res[msb]!=A[msb]).
- SUB: V = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
- MUL: V = (acc[2W-1:W] != 0), i.e. unsigned overflow.
- Logic ops: V=0.
- All ops: Z and N are derived from the written result.

Decomposition:
- Package alu_pkg holds:
  - ALUop localparams (OP_ADD … OP_MUL, OP_RSV);
  - state encodings (S_IDLE, S_MUL, S_FIN);
  - a flag-computation function.
- One sub-module, alu_mul_iter, is natural: the shift-add multiplier datapath.
  - Ports: clk, reset_n, load, A, B, step, acc, last.
  - alu_mc holds the FSM, the single-cycle ops and the output registers.

Test Plan:
(WIDTH=16 unless noted)
1. ADD 0x1993 + 0x846C -> out=0x9DFF, Z=0, N=1, V=0, done high exactly one cycle after the start edge. Then NOT B, Bin=0x1993 -> out=0xE66C, Z=0, N=1, V=0.
2. SUB 0x0002 - 0x0004 -> out=0xFFFE, N=1, V=0. ADD 0x8000 + 0x8000 -> out=0x0000, Z=1, V=1. SUB 0x8000 - 0x0001 -> out=0x7FFF, V=1, N=0.
3. MUL 0x0012 × 0x0034:
   - busy=1 for 17 cycles; done at edge 17 after sampling;
   - out=0x03A8, V=0;
   - out holds its previous value until that edge.
   MUL 0x0100 × 0x0100 -> out=0x0000, Z=1, V=1.
4. start with ADD 0x0001 + 0x0001 pulsed while busy=1 (cycle 5 of a MUL) -> ignored: no extra done, MUL result unchanged. Back-to-back ADDs in IDLE give done on 2 consecutive cycles with correct outputs.
5. reset_n low during cycle 6 of a MUL:
   - immediately (before the next clk) out=0, Z=1, busy=0, done=0;
   - after release, ADD 0x0003 + 0x0004 -> out=0x0007 one cycle later.
6. WIDTH=8, MUL 0x0F × 0x11 -> out=0xFF, V=0, done after 9 edges. Op 111 -> out=0x00, Z=1, V=0.
